// File: rtl/sub32_pipe_pkg.sv
// sub32_pipe_pkg
// Shared definitions for the four-lane saturating subtract pipeline.
// Holds the lane width, the positions of the status bits in each lane's
// status word, and the signed saturation limits. It also provides a helper
// that packs one lane's status flags into its 32-bit status word.
package sub32_pipe_pkg;

    localparam int LANE_W = 32;

    // Bit positions inside each lane's 32-bit status word.
    localparam int ST_SAT = 3;
    localparam int ST_GT  = 2;
    localparam int ST_EQ  = 1;
    localparam int ST_LS  = 0;

    // Signed saturation limits.
    localparam logic [LANE_W-1:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [LANE_W-1:0] SAT_NEG = 32'h8000_0000;

    // Flags produced by one lane. The field order matches the layout of the
    // status word.
    typedef struct packed {
        logic sat;
        logic gt;
        logic eq;
        logic ls;
    } lane_status_t;

    // Place each flag at its own index. Every other bit of the word is zero.
    function automatic logic [LANE_W-1:0] pack_status(input lane_status_t s);
        logic [LANE_W-1:0] w;
        w         = '0;
        w[ST_SAT] = s.sat;
        w[ST_GT]  = s.gt;
        w[ST_EQ]  = s.eq;
        w[ST_LS]  = s.ls;
        return w;
    endfunction

endpackage

// File: rtl/sub32_lane.sv
// sub32_lane
// Combinational 32-bit saturating subtract for one lane.
// Ports:
//   a, b        : minuend and subtrahend
//   signed_mode : 1 = two's complement operands, 0 = unsigned operands
//   diff        : a - b, saturated to the 32-bit range of the mode
//   sat         : the difference was clamped
//   gt, eq, ls  : a > b, a == b, a < b in the active mode (exactly one is set)
module sub32_lane
    import sub32_pipe_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              signed_mode,
    output logic [LANE_W-1:0] diff,
    output logic              sat,
    output logic              gt,
    output logic              eq,
    output logic              ls
);

    logic [LANE_W:0] a_ext;
    logic [LANE_W:0] b_ext;
    logic [LANE_W:0] d_ext;

    // In both modes the true difference fits in 33-bit two's complement.
    // The top bit of d_ext is therefore the real sign of a - b, and it also
    // gives the a < b result for the magnitude compare.
    // In signed mode, bits 32 and 31 differ only when the result falls
    // outside the 32-bit signed range.
    always_comb begin
        a_ext = {signed_mode & a[LANE_W-1], a};
        b_ext = {signed_mode & b[LANE_W-1], b};
        d_ext = a_ext - b_ext;

        ls   = d_ext[LANE_W];
        eq   = (a == b);
        gt   = !ls && !eq;

        diff = d_ext[LANE_W-1:0];
        sat  = 1'b0;

        if (signed_mode) begin
            if (d_ext[LANE_W] != d_ext[LANE_W-1]) begin
                sat  = 1'b1;
                diff = d_ext[LANE_W] ? SAT_NEG : SAT_POS;
            end
        end else if (ls) begin
            sat  = 1'b1;
            diff = '0;
        end
    end

endmodule

// File: rtl/sub32_pipe.sv
// sub32_pipe
// Two-stage pipelined saturating subtract over LANES x 32-bit lanes.
// Only LANES = 4 is supported.
// Stage 1 registers the operands and the mode. Stage 2 registers the
// per-lane saturated difference and the status word.
// Ports:
//   clk, rst_n         : clock; asynchronous active-low reset
//   in_valid, in_ready : input handshake
//   src0, src1         : packed lane operands; lane i = bits [i*32+31:i*32]
//   sign_s0, sign_s1   : signed mode when either one is set
//   out_valid, out_ready : output handshake
//   dst                : per-lane saturated difference
//   st                 : per-lane status; lane bits [3:0] = {sat, gt, eq, ls}
//   sat_clr            : synchronous clear of sat_cnt
//   sat_cnt            : saturating count of clamped lanes that were delivered
module sub32_pipe
    import sub32_pipe_pkg::*;
#(
    parameter int LANES = 4,
    parameter int SATW  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] src0,
    input  logic [LANES*LANE_W-1:0] src1,
    input  logic                    sign_s0,
    input  logic                    sign_s1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] dst,
    output logic [LANES*LANE_W-1:0] st,
    input  logic                    sat_clr,
    output logic [SATW-1:0]         sat_cnt
);

    localparam int DW    = LANES * LANE_W;
    localparam int CNT_W = $clog2(LANES + 1);

    logic          advance;
    logic          s1_valid;
    logic [DW-1:0] s1_src0;
    logic [DW-1:0] s1_src1;
    logic          s1_signed;
    logic [DW-1:0] dst_next;
    logic [DW-1:0] st_next;
    logic [CNT_W-1:0] sat_lanes;
    logic [SATW:0]    sat_sum;
    logic [SATW-1:0]  sat_next;

    // The whole pipeline moves together. It stops only while a result is
    // waiting at the output and the consumer is not taking it.
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    // Stage 1. Operand registers are loaded only for real beats, so idle
    // inputs never disturb any state. An empty slot still advances, which
    // lets bubbles flow through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_src0   <= '0;
            s1_src1   <= '0;
            s1_signed <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_src0   <= src0;
                s1_src1   <= src1;
                s1_signed <= sign_s0 || sign_s1;
            end
        end
    end

    // One combinational lane per 32-bit slice sits between the two stages.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0] lane_diff;
        logic              lane_sat;
        logic              lane_gt;
        logic              lane_eq;
        logic              lane_ls;
        lane_status_t      lane_stat;

        sub32_lane u_lane (
            .a           (s1_src0[i*LANE_W +: LANE_W]),
            .b           (s1_src1[i*LANE_W +: LANE_W]),
            .signed_mode (s1_signed),
            .diff        (lane_diff),
            .sat         (lane_sat),
            .gt          (lane_gt),
            .eq          (lane_eq),
            .ls          (lane_ls)
        );

        assign lane_stat                    = {lane_sat, lane_gt, lane_eq, lane_ls};
        assign dst_next[i*LANE_W +: LANE_W] = lane_diff;
        assign st_next[i*LANE_W +: LANE_W]  = pack_status(lane_stat);
    end

    // Stage 2. When stage 1 is empty and the pipe advances, out_valid drops.
    // dst and st keep their last values because nobody consumes them then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dst       <= '0;
            st        <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                dst <= dst_next;
                st  <= st_next;
            end
        end
    end

    // Count the sat flags of the beat currently on the output. The sum is
    // one bit wider than sat_cnt. Each step adds at most LANES, so a carry
    // into that extra bit means the count has passed its maximum.
    always_comb begin
        sat_lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            sat_lanes = sat_lanes + CNT_W'(st[i*LANE_W + ST_SAT]);
        end
        sat_sum  = {1'b0, sat_cnt} + (SATW+1)'(sat_lanes);
        sat_next = sat_sum[SATW] ? {SATW{1'b1}} : sat_sum[SATW-1:0];
    end

    // A clear wins over an increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready) begin
            sat_cnt <= sat_next;
        end
    end

endmodule
